// File: rtl/lif_stream_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : lif_stream_loader_if
// Description : Host/tile signal bundle for the LIF stream loader: request
//               handshake, parallel vectors, byte bus and spike return.
// Revision    : 1.0 - initial release
// ============================================================================
interface lif_stream_loader_if #(
    parameter int N_STAGES = 5,
    parameter int RUN_BITS = 8
);
    localparam int INPUTS = 2 ** N_STAGES;

    logic                start;
    logic                ready;
    logic                load_weights;
    logic [INPUTS-1:0]   weights_in;
    logic [INPUTS-1:0]   inputs_in;
    logic [RUN_BITS-1:0] run_cycles;
    logic [7:0]          data_out;
    logic                weights_sel;
    logic                load_n;
    logic                spike_in;
    logic [RUN_BITS-1:0] spike_count;
    logic                done;

    // Host / testbench side
    modport master (
        output start, load_weights, weights_in, inputs_in, run_cycles, spike_in,
        input  ready, data_out, weights_sel, load_n, spike_count, done
    );

    // Loader side
    modport slave (
        input  start, load_weights, weights_in, inputs_in, run_cycles, spike_in,
        output ready, data_out, weights_sel, load_n, spike_count, done
    );
endinterface
`default_nettype wire

// File: rtl/lif_stream_loader.sv
`default_nettype none
// ============================================================================
// Module      : lif_stream_loader
// Description : Streams a weight vector and an input vector MSB-byte-first to
//               a LIF neuron tile, then holds the tile in integrate mode for a
//               programmed window while counting returned spikes.
// Revision    : 1.0 - initial release
// ============================================================================
module lif_stream_loader #(
    parameter int N_STAGES = 5,
    parameter int RUN_BITS = 8
) (
    input  wire logic          clk,
    input  wire logic          reset,
    lif_stream_loader_if.slave bus
);
    localparam int INPUTS = 2 ** N_STAGES;
    localparam int BYTES  = INPUTS / 8;
    // Counter must index both a byte within a vector and a RUN window cycle.
    localparam int CNT_W  = (RUN_BITS > N_STAGES) ? RUN_BITS : N_STAGES;

    localparam logic [CNT_W-1:0]    c_LAST_BYTE = CNT_W'(BYTES - 1);
    localparam logic [RUN_BITS-1:0] c_SPK_MAX   = '1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_W = 3'd1,
        S_LOAD_I = 3'd2,
        S_RUN    = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_state_nx;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_nx;
    logic [CNT_W-1:0]    w_run_last;
    logic [INPUTS-1:0]   r_wsh;
    logic [INPUTS-1:0]   r_ish;
    logic [RUN_BITS-1:0] r_run;
    logic [RUN_BITS-1:0] r_spk;
    logic [7:0]          r_data;
    logic [7:0]          w_byte;
    logic                w_use_w;
    logic                w_use_i;
    logic                w_accept;
    logic                r_wsel;
    logic                r_load_n;
    logic                r_ready;
    logic                r_done;

    assign w_accept   = bus.start & r_ready;
    assign w_run_last = CNT_W'(r_run) - CNT_W'(1);

    // Next-state and byte/window counter; counter restarts on every state change.
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt + CNT_W'(1);
        case (r_state)
            S_IDLE: begin
                w_cnt_nx = '0;
                if (w_accept) begin
                    w_state_nx = bus.load_weights ? S_LOAD_W : S_LOAD_I;
                end
            end
            S_LOAD_W: begin
                if (r_cnt == c_LAST_BYTE) begin
                    w_state_nx = S_LOAD_I;
                    w_cnt_nx   = '0;
                end
            end
            S_LOAD_I: begin
                if (r_cnt == c_LAST_BYTE) begin
                    w_state_nx = (r_run != '0) ? S_RUN : S_DONE;
                    w_cnt_nx   = '0;
                end
            end
            S_RUN: begin
                if (r_cnt == w_run_last) begin
                    w_state_nx = S_DONE;
                    w_cnt_nx   = '0;
                end
            end
            S_DONE: begin
                w_state_nx = S_IDLE;
                w_cnt_nx   = '0;
            end
            default: begin
                w_state_nx = S_IDLE;
                w_cnt_nx   = '0;
            end
        endcase
    end

    // Byte to present next cycle: taken straight from the port vectors on
    // accept, otherwise from the head of the active shift register.
    always_comb begin
        w_byte  = '0;
        w_use_w = 1'b0;
        w_use_i = 1'b0;
        if (w_accept) begin
            w_byte = bus.load_weights ? bus.weights_in[INPUTS-1 -: 8]
                                      : bus.inputs_in[INPUTS-1 -: 8];
        end else if (w_state_nx == S_LOAD_W) begin
            w_byte  = r_wsh[INPUTS-1 -: 8];
            w_use_w = 1'b1;
        end else if (w_state_nx == S_LOAD_I) begin
            w_byte  = r_ish[INPUTS-1 -: 8];
            w_use_i = 1'b1;
        end
    end

    // State, vector capture/shift, spike counting and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_wsh    <= '0;
            r_ish    <= '0;
            r_run    <= '0;
            r_spk    <= '0;
            r_data   <= '0;
            r_wsel   <= 1'b0;
            r_load_n <= 1'b0;
            r_ready  <= 1'b1;
            r_done   <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            if (w_accept) begin
                r_run <= bus.run_cycles;
                r_spk <= '0;
                // The first byte leaves on this edge, so the vector that
                // supplies it is stored already advanced by one byte.
                if (bus.load_weights) begin
                    r_wsh <= bus.weights_in << 8;
                    r_ish <= bus.inputs_in;
                end else begin
                    r_wsh <= bus.weights_in;
                    r_ish <= bus.inputs_in << 8;
                end
            end else begin
                if (w_use_w) begin
                    r_wsh <= r_wsh << 8;
                end
                if (w_use_i) begin
                    r_ish <= r_ish << 8;
                end
                if ((r_state == S_RUN) && bus.spike_in && (r_spk != c_SPK_MAX)) begin
                    r_spk <= r_spk + RUN_BITS'(1);
                end
            end
            r_data   <= w_byte;
            r_wsel   <= (w_state_nx == S_LOAD_W);
            r_load_n <= (w_state_nx == S_RUN);
            r_ready  <= (w_state_nx == S_IDLE);
            r_done   <= (w_state_nx == S_DONE);
        end
    end

    assign bus.ready       = r_ready;
    assign bus.data_out    = r_data;
    assign bus.weights_sel = r_wsel;
    assign bus.load_n      = r_load_n;
    assign bus.spike_count = r_spk;
    assign bus.done        = r_done;

endmodule
`default_nettype wire

// File: tb/tb_lif_stream_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_lif_stream_loader
// Description : Directed, table-driven bench for lif_stream_loader
//               (N_STAGES=5, RUN_BITS=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lif_stream_loader;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    lif_stream_loader_if #(.N_STAGES(5), .RUN_BITS(8)) bus ();

    lif_stream_loader #(.N_STAGES(5), .RUN_BITS(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        lw;
        logic [31:0] w;
        logic [31:0] i;
        logic [7:0]  run;
        logic [7:0]  pat;       // bit j = spike_in during RUN cycle j
        logic        idle_spk;  // spike_in outside the RUN window
        logic [63:0] bytes;     // expected byte stream, last byte in [7:0]
        int          nw;        // number of weight bytes
        int          nb;        // total bytes streamed
        int          done_cyc;  // cycle after accept where done is high
        logic [7:0]  cnt;       // expected spike_count at done
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        logic [7:0] exp_d;
        logic       exp_ws;
        logic       exp_ln;
        chk({tag, " ready_at_accept"}, 64'(bus.ready), 64'd1);
        bus.start        = 1'b1;
        bus.load_weights = v.lw;
        bus.weights_in   = v.w;
        bus.inputs_in    = v.i;
        bus.run_cycles   = v.run;
        bus.spike_in     = v.idle_spk;
        for (int c = 1; c <= v.done_cyc; c++) begin
            step();
            if (c == 1) bus.start = 1'b0;
            if (c <= v.nb) begin
                exp_d  = v.bytes[8*(v.nb-c) +: 8];
                exp_ws = (c <= v.nw);
                exp_ln = 1'b0;
            end else if (c <= v.nb + int'(v.run)) begin
                exp_d  = 8'h00;
                exp_ws = 1'b0;
                exp_ln = 1'b1;
            end else begin
                exp_d  = 8'h00;
                exp_ws = 1'b0;
                exp_ln = 1'b0;
            end
            chk($sformatf("%s c%0d data_out", tag, c), 64'(bus.data_out), 64'(exp_d));
            chk($sformatf("%s c%0d weights_sel", tag, c), 64'(bus.weights_sel), 64'(exp_ws));
            chk($sformatf("%s c%0d load_n", tag, c), 64'(bus.load_n), 64'(exp_ln));
            chk($sformatf("%s c%0d done", tag, c), 64'(bus.done), 64'(c == v.done_cyc));
            chk($sformatf("%s c%0d ready", tag, c), 64'(bus.ready), 64'd0);
            if (c == v.done_cyc)
                chk({tag, " spike_count_at_done"}, 64'(bus.spike_count), 64'(v.cnt));
            if (c >= v.nb + 1 && c <= v.nb + int'(v.run))
                bus.spike_in = v.pat[c - v.nb - 1];
            else
                bus.spike_in = v.idle_spk;
        end
        bus.spike_in = 1'b0;
        step();
        chk({tag, " ready_after"}, 64'(bus.ready), 64'd1);
        chk({tag, " done_after"}, 64'(bus.done), 64'd0);
        chk({tag, " count_held"}, 64'(bus.spike_count), 64'(v.cnt));
    endtask

    initial begin
        int k;
        vecs[0] = '{1'b1, 32'hF0F00FF0, 32'h12345678, 8'd0, 8'h00, 1'b0,
                    64'hF0F00FF0_12345678, 4, 8, 9, 8'd0};
        vecs[1] = '{1'b0, 32'hFFFFFFFF, 32'hAABBCCDD, 8'd0, 8'h00, 1'b0,
                    64'h00000000_AABBCCDD, 0, 4, 5, 8'd0};
        vecs[2] = '{1'b0, 32'h00000000, 32'h01020304, 8'd3, 8'b111, 1'b1,
                    64'h00000000_01020304, 0, 4, 8, 8'd3};
        vecs[3] = '{1'b0, 32'h00000000, 32'h0A0B0C0D, 8'd3, 8'b101, 1'b0,
                    64'h00000000_0A0B0C0D, 0, 4, 8, 8'd2};
        vecs[4] = '{1'b1, 32'hDEADBEEF, 32'hCAFEF00D, 8'd5, 8'b01101, 1'b0,
                    64'hDEADBEEF_CAFEF00D, 4, 8, 14, 8'd3};

        reset            = 1'b1;
        bus.start        = 1'b0;
        bus.load_weights = 1'b0;
        bus.weights_in   = '0;
        bus.inputs_in    = '0;
        bus.run_cycles   = '0;
        bus.spike_in     = 1'b0;

        // Reset held two cycles
        step();
        step();
        chk("rst ready", 64'(bus.ready), 64'd1);
        chk("rst load_n", 64'(bus.load_n), 64'd0);
        chk("rst weights_sel", 64'(bus.weights_sel), 64'd0);
        chk("rst data_out", 64'(bus.data_out), 64'd0);
        chk("rst done", 64'(bus.done), 64'd0);
        chk("rst spike_count", 64'(bus.spike_count), 64'd0);
        reset = 1'b0;
        step();

        for (int v = 0; v < 5; v++) begin
            run_vec(vecs[v], $sformatf("vec%0d", v));
        end

        // Reset during the second LOAD_I byte
        bus.start        = 1'b1;
        bus.load_weights = 1'b0;
        bus.inputs_in    = 32'h11223344;
        bus.run_cycles   = 8'd2;
        step();
        bus.start = 1'b0;
        chk("abort byte0", 64'(bus.data_out), 64'h11);
        step();
        chk("abort byte1", 64'(bus.data_out), 64'h22);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("abort ready", 64'(bus.ready), 64'd1);
        chk("abort load_n", 64'(bus.load_n), 64'd0);
        chk("abort data_out", 64'(bus.data_out), 64'd0);
        chk("abort weights_sel", 64'(bus.weights_sel), 64'd0);
        chk("abort done", 64'(bus.done), 64'd0);
        run_vec(vecs[1], "after_abort");

        // Start pulsed in RUN is ignored; start held through DONE is accepted
        // on the following IDLE cycle.
        bus.start        = 1'b1;
        bus.load_weights = 1'b0;
        bus.inputs_in    = 32'h55667788;
        bus.run_cycles   = 8'd4;
        bus.spike_in     = 1'b1;
        step();                                   // c1
        bus.start = 1'b0;
        chk("held c1 data", 64'(bus.data_out), 64'h55);
        for (int c = 2; c <= 5; c++) step();      // c5
        chk("held c5 load_n", 64'(bus.load_n), 64'd1);
        step();                                   // c6
        bus.start = 1'b1;
        chk("held c6 ready", 64'(bus.ready), 64'd0);
        step();                                   // c7
        bus.start = 1'b0;
        chk("held c7 load_n", 64'(bus.load_n), 64'd1);
        chk("held c7 data", 64'(bus.data_out), 64'd0);
        chk("held c7 ready", 64'(bus.ready), 64'd0);
        step();                                   // c8
        chk("held c8 load_n", 64'(bus.load_n), 64'd1);
        bus.start = 1'b1;
        step();                                   // c9 DONE
        chk("held c9 done", 64'(bus.done), 64'd1);
        chk("held c9 ready", 64'(bus.ready), 64'd0);
        chk("held c9 count", 64'(bus.spike_count), 64'd4);
        step();                                   // c10 IDLE, accept here
        chk("held c10 ready", 64'(bus.ready), 64'd1);
        chk("held c10 done", 64'(bus.done), 64'd0);
        chk("held c10 count", 64'(bus.spike_count), 64'd4);
        step();                                   // new transaction cycle 1
        chk("reacc ready", 64'(bus.ready), 64'd0);
        chk("reacc data", 64'(bus.data_out), 64'h55);
        chk("reacc count_cleared", 64'(bus.spike_count), 64'd0);
        bus.start    = 1'b0;
        bus.spike_in = 1'b0;
        k = 0;
        while (k < 30 && bus.done !== 1'b1) begin
            step();
            k++;
        end
        chk("reacc done_seen", 64'(bus.done), 64'd1);
        chk("reacc done_latency", 64'(k), 64'd8);
        chk("reacc count", 64'(bus.spike_count), 64'd0);
        step();
        chk("reacc ready_after", 64'(bus.ready), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
